// File: rtl/ppu_pkg.sv
// Shared PPU definitions: CPU register selects, OAM DMA state encoding and the
// attribute-byte read mask helper.
package ppu_pkg;

  localparam logic [1:0] REG_OAMADDR = 2'd0;
  localparam logic [1:0] REG_OAMDATA = 2'd1;
  localparam logic [1:0] REG_OAMDMA  = 2'd2;

  typedef enum logic [2:0] {
    IDLE,
    HALT,
    ALIGN,
    READ,
    WRITE,
    DONE
  } dma_state_e;

  // Attribute bytes sit at addr[1:0]==2 within each 4-byte sprite entry.
  function automatic logic [7:0] attr_mask(input logic [7:0] addr, input logic [7:0] data,
                                           input logic [7:0] mask);
    return (addr[1:0] == 2'd2) ? (data & mask) : data;
  endfunction

endpackage

// File: rtl/oam_ram.sv
// 256x8 OAM storage: one synchronous write port, two combinational read ports
// (CPU side and sprite engine side).
module oam_ram (
  input  logic       i_clock,
  input  logic       i_we,
  input  logic [7:0] i_waddr,
  input  logic [7:0] i_wdata,
  input  logic [7:0] i_cpu_raddr,
  output logic [7:0] o_cpu_rdata,
  input  logic [7:0] i_se_raddr,
  output logic [7:0] o_se_rdata
);

  logic [7:0] r_mem [256];

  always_ff @(posedge i_clock) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_cpu_rdata = r_mem[i_cpu_raddr];
  assign o_se_rdata  = r_mem[i_se_raddr];

endmodule

// File: rtl/oam_dma.sv
// Primary OAM with the OAMADDR/OAMDATA register interface and the $4014 sprite DMA engine.
// Define OAM_ATTR_MASK_EN to make attribute bytes read back with RD_MASK applied.
module oam_dma
  import ppu_pkg::*;
#(
  parameter int unsigned DMA_LEN = 256,
  parameter logic [7:0]  RD_MASK = 8'hE3
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_cpu_ce,
  input  logic        i_cpu_odd,
  input  logic        i_cpu_wr,
  input  logic        i_cpu_rd,
  input  logic [1:0]  i_cpu_reg,
  input  logic [7:0]  i_cpu_wdata,
  output logic [7:0]  o_cpu_rdata,
  output logic        o_cpu_halt,
  output logic [15:0] o_dma_addr,
  output logic        o_dma_rd,
  input  logic [7:0]  i_dma_data,
  input  logic [7:0]  i_se_addr,
  output logic [7:0]  o_se_data,
  output logic        o_dma_busy
);

`ifdef OAM_ATTR_MASK_EN
  localparam logic [7:0] ReadMask = RD_MASK;
`else
  localparam logic [7:0] ReadMask = 8'hFF & (RD_MASK | 8'hFF);
`endif

  dma_state_e r_state, w_state_next;
  logic [7:0] r_oam_addr;
  logic [7:0] r_page;
  logic [7:0] r_idx;
  logic [7:0] r_rdata;

  logic       w_busy;
  logic       w_cpu_wr;
  logic       w_cpu_rd;
  logic       w_dma_wr;
  logic       w_last;
  logic       w_ram_we;
  logic [7:0] w_ram_wdata;
  logic [7:0] w_cpu_raw;
  logic [7:0] w_se_raw;

  // DONE already releases the CPU, so register accesses are accepted there.
  assign w_busy   = (r_state != IDLE) && (r_state != DONE);
  assign w_cpu_wr = i_cpu_ce && !w_busy && i_cpu_wr;
  assign w_cpu_rd = i_cpu_ce && !w_busy && i_cpu_rd && !i_cpu_wr &&
                    (i_cpu_reg == REG_OAMDATA);
  assign w_dma_wr = i_cpu_ce && (r_state == WRITE);
  assign w_last   = (r_idx == 8'(DMA_LEN - 1));

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    if (i_cpu_ce) begin
      unique case (r_state)
        IDLE, DONE: begin
          w_state_next = (w_cpu_wr && (i_cpu_reg == REG_OAMDMA)) ? HALT : IDLE;
        end
        HALT:    w_state_next = i_cpu_odd ? ALIGN : READ;
        ALIGN:   w_state_next = READ;
        READ:    w_state_next = WRITE;
        WRITE:   w_state_next = w_last ? DONE : READ;
        default: w_state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_oam_addr <= 8'h00;
      r_page     <= 8'h00;
      r_idx      <= 8'h00;
      r_rdata    <= 8'h00;
    end else begin
      if (w_cpu_wr) begin
        case (i_cpu_reg)
          REG_OAMADDR: r_oam_addr <= i_cpu_wdata;
          REG_OAMDATA: r_oam_addr <= r_oam_addr + 8'd1;
          REG_OAMDMA: begin
            r_page <= i_cpu_wdata;
            r_idx  <= 8'h00;
          end
          default: ;
        endcase
      end
      if (w_cpu_rd) begin
        r_rdata <= attr_mask(r_oam_addr, w_cpu_raw, ReadMask);
      end
      // A full-length copy advances oam_addr 256 times, landing back on its start.
      if (w_dma_wr) begin
        r_oam_addr <= r_oam_addr + 8'd1;
        r_idx      <= r_idx + 8'd1;
      end
    end
  end

  always_comb begin
    w_ram_we    = 1'b0;
    w_ram_wdata = i_cpu_wdata;
    if (w_dma_wr) begin
      w_ram_we    = 1'b1;
      w_ram_wdata = i_dma_data;
    end else if (w_cpu_wr && (i_cpu_reg == REG_OAMDATA)) begin
      w_ram_we    = 1'b1;
    end
  end

  oam_ram u_oam_ram (
    .i_clock     (i_clock),
    .i_we        (w_ram_we),
    .i_waddr     (r_oam_addr),
    .i_wdata     (w_ram_wdata),
    .i_cpu_raddr (r_oam_addr),
    .o_cpu_rdata (w_cpu_raw),
    .i_se_raddr  (i_se_addr),
    .o_se_rdata  (w_se_raw)
  );

  assign o_cpu_rdata = r_rdata;
  assign o_cpu_halt  = w_busy;
  assign o_dma_busy  = w_busy;
  assign o_dma_rd    = (r_state == READ);
  assign o_dma_addr  = {r_page, r_idx};
  assign o_se_data   = attr_mask(i_se_addr, w_se_raw, ReadMask);

endmodule

// File: tb/tb_oam_dma.sv
// Randomised bench for oam_dma against a cycle-count model of OAM, the register file and DMA.
// Honours OAM_ATTR_MASK_EN the same way the design does.
`timescale 1ns/1ps
module tb_oam_dma;

`ifdef OAM_ATTR_MASK_EN
  localparam logic [7:0] MASK = 8'hE3;
`else
  localparam logic [7:0] MASK = 8'hFF;
`endif

  logic        clock = 1'b0;
  logic        reset;
  logic        cpu_ce, cpu_odd, cpu_wr, cpu_rd;
  logic [1:0]  cpu_reg;
  logic [7:0]  cpu_wdata, cpu_rdata, dma_data, se_addr, se_data;
  logic        cpu_halt, dma_rd, dma_busy;
  logic [15:0] dma_addr;

  oam_dma dut (
    .i_clock     (clock),
    .i_reset     (reset),
    .i_cpu_ce    (cpu_ce),
    .i_cpu_odd   (cpu_odd),
    .i_cpu_wr    (cpu_wr),
    .i_cpu_rd    (cpu_rd),
    .i_cpu_reg   (cpu_reg),
    .i_cpu_wdata (cpu_wdata),
    .o_cpu_rdata (cpu_rdata),
    .o_cpu_halt  (cpu_halt),
    .o_dma_addr  (dma_addr),
    .o_dma_rd    (dma_rd),
    .i_dma_data  (dma_data),
    .i_se_addr   (se_addr),
    .o_se_data   (se_data),
    .o_dma_busy  (dma_busy)
  );

  always #5 clock = ~clock;

  int n_total = 0;
  int n_bad   = 0;

  // Model state
  logic [7:0]  m_oam [256];
  bit          m_val [256];
  logic [7:0]  m_addr, m_rdata, m_page, m_base, m_xor;
  bit          m_dma;
  int          m_n, m_a, m_len, m_r, m_written;
  int          cyc;
  // Expectations for the current CPU cycle
  logic        e_halt, e_rd, e_se_ok;
  logic [15:0] e_addr;
  logic [7:0]  e_rdata, e_se;
  int          halt_cnt;
  logic [15:0] first_rd, last_rd;
  bit          seen_rd;

  function automatic logic [7:0] rd_view(input logic [7:0] a, input logic [7:0] d);
    return (a[1:0] == 2'b10) ? (d & MASK) : d;
  endfunction

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (cpu cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Source memory seen by the DMA: one cycle of read latency.
  always @(posedge clock) begin
    if (cpu_ce && dma_rd) dma_data <= dma_addr[7:0] ^ m_xor;
  end

  // Compare process: every CPU cycle, mid-way between the setup and the active edge.
  always @(negedge clock) begin
    if (cpu_ce && !reset) begin
      chk("cpu_halt", {15'd0, cpu_halt}, {15'd0, e_halt});
      chk("dma_busy", {15'd0, dma_busy}, {15'd0, e_halt});
      chk("dma_rd", {15'd0, dma_rd}, {15'd0, e_rd});
      if (e_rd) chk("dma_addr", dma_addr, e_addr);
      chk("cpu_rdata", {8'd0, cpu_rdata}, {8'd0, e_rdata});
      if (e_se_ok) chk("se_data", {8'd0, se_data}, {8'd0, e_se});
      if (cpu_halt) halt_cnt++;
      if (dma_rd) begin
        if (!seen_rd) first_rd = dma_addr;
        seen_rd = 1'b1;
        last_rd = dma_addr;
      end
    end
  end

  task automatic step(input logic wr, input logic rd, input logic [1:0] rg, input logic [7:0] wd);
    bit dma_pre;
    int k;
    @(posedge clock); #1;
    cpu_ce = 1'b1; cpu_wr = wr; cpu_rd = rd; cpu_reg = rg; cpu_wdata = wd;
    cpu_odd = (cyc % 2) == 1;
    se_addr = 8'($urandom);
    dma_pre = m_dma;
    m_r = cyc - m_n;
    if (m_dma && m_r == 1) begin
      m_a = cpu_odd ? 1 : 0;
      m_len = 513 + m_a;
    end
    e_halt = m_dma && m_r >= 1 && m_r <= m_len;
    e_rd = 1'b0;
    if (e_halt && m_r >= 2 + m_a && ((m_r - 2 - m_a) % 2) == 0) begin
      e_rd = 1'b1;
      e_addr = {m_page, 8'((m_r - 2 - m_a) / 2)};
    end
    e_rdata = m_rdata;
    e_se_ok = m_val[se_addr];
    e_se = rd_view(se_addr, m_oam[se_addr]);
    @(posedge clock); #1;
    if (dma_pre && e_halt && m_r >= 3 + m_a && ((m_r - 3 - m_a) % 2) == 0) begin
      k = (m_r - 3 - m_a) / 2;
      m_oam[8'(m_base + k)] = 8'(k) ^ m_xor;
      m_val[8'(m_base + k)] = 1'b1;
      m_written++;
    end
    if (dma_pre && m_r == m_len + 1) m_dma = 1'b0;
    if (!e_halt) begin
      if (wr) begin
        case (rg)
          2'd0: m_addr = wd;
          2'd1: begin m_oam[m_addr] = wd; m_val[m_addr] = 1'b1; m_addr++; end
          2'd2: begin
            m_dma = 1'b1; m_n = cyc; m_page = wd; m_base = m_addr; m_written = 0; m_len = 1000;
          end
          default: ;
        endcase
      end else if (rd && rg == 2'd1) begin
        m_rdata = rd_view(m_addr, m_oam[m_addr]);
      end
    end
    cpu_ce = 1'b0; cpu_wr = 1'b0; cpu_rd = 1'b0;
    @(posedge clock);
    cyc++;
  endtask

  task automatic nop();
    step(1'b0, 1'b0, 2'd3, 8'h00);
  endtask

  task automatic se_chk(input string nm, input logic [7:0] a, input logic [7:0] exp);
    se_addr = a; #1;
    chk(nm, {8'd0, se_data}, {8'd0, exp});
  endtask

  task automatic run_dma(input logic [7:0] page, input logic [7:0] x, input int odd,
                         input bit inject);
    logic [7:0] base;
    m_xor = x;
    for (int i = 0; i < 4 && ((cyc + 1) % 2) != odd; i++) nop();
    base = m_addr;
    halt_cnt = 0; seen_rd = 1'b0;
    step(1'b1, 1'b0, 2'd2, page);
    for (int i = 0; i < 700 && m_dma; i++) begin
      if (inject && (cyc - m_n) >= 1 && (cyc - m_n) < 500)
        step(1'($urandom), 1'($urandom), 2'($urandom), 8'($urandom));
      else nop();
    end
    nop();
    chk("halt_dropped", {15'd0, cpu_halt}, 16'd0);
    chk("halt_len", 16'(halt_cnt), 16'(513 + odd));
    chk("dma_first_addr", first_rd, {page, 8'h00});
    chk("dma_last_addr", last_rd, {page, 8'hFF});
    for (int i = 0; i < 256; i++) se_chk("oam_after_dma", 8'(i), rd_view(8'(i), 8'(i - base) ^ x));
  endtask

  initial begin
    reset = 1'b1; cpu_ce = 0; cpu_odd = 0; cpu_wr = 0; cpu_rd = 0; cpu_reg = 2'd3;
    cpu_wdata = 0; dma_data = 0; se_addr = 0; cyc = 0;
    m_addr = 0; m_rdata = 0; m_dma = 0; m_n = 0; m_a = 0; m_len = 1000; m_xor = 0;
    m_page = 0; m_base = 0; m_written = 0; halt_cnt = 0; seen_rd = 0;
    for (int i = 0; i < 256; i++) m_val[i] = 1'b0;
    #12;
    chk("rst_halt", {15'd0, cpu_halt}, 16'd0);
    chk("rst_busy", {15'd0, dma_busy}, 16'd0);
    chk("rst_dma_rd", {15'd0, dma_rd}, 16'd0);
    chk("rst_dma_addr", dma_addr, 16'h0000);
    chk("rst_rdata", {8'd0, cpu_rdata}, 16'd0);
    @(negedge clock); reset = 1'b0;

    // Fill OAM from address 0 so every entry is known.
    step(1'b1, 1'b0, 2'd0, 8'h00);
    for (int i = 0; i < 256; i++) step(1'b1, 1'b0, 2'd1, 8'($urandom));

    // OAMDATA writes wrap past 255.
    step(1'b1, 1'b0, 2'd0, 8'hFE);
    step(1'b1, 1'b0, 2'd1, 8'h11);
    step(1'b1, 1'b0, 2'd1, 8'h22);
    step(1'b1, 1'b0, 2'd1, 8'h33);
    se_chk("wrap_fe", 8'hFE, 8'h11 & MASK);
    se_chk("wrap_ff", 8'hFF, 8'h22);
    se_chk("wrap_00", 8'h00, 8'h33);
    step(1'b1, 1'b0, 2'd1, 8'h44);
    se_chk("wrap_addr01", 8'h01, 8'h44);

    // Reads do not advance oam_addr; write+read together acts as a write.
    step(1'b1, 1'b0, 2'd0, 8'h10);
    step(1'b1, 1'b0, 2'd1, 8'h9C);
    step(1'b1, 1'b0, 2'd0, 8'h10);
    step(1'b0, 1'b1, 2'd1, 8'h00);
    chk("read1", {8'd0, cpu_rdata}, 16'h009C);
    step(1'b0, 1'b1, 2'd1, 8'h00);
    chk("read2", {8'd0, cpu_rdata}, 16'h009C);
    se_chk("se_10", 8'h10, 8'h9C);
    step(1'b1, 1'b1, 2'd1, 8'h77);
    chk("wr_beats_rd", {8'd0, cpu_rdata}, 16'h009C);
    se_chk("addr_stayed", 8'h10, 8'h77);
    step(1'b1, 1'b0, 2'd3, 8'h55);

    // Attribute byte masking.
    step(1'b1, 1'b0, 2'd0, 8'h02);
    step(1'b1, 1'b0, 2'd1, 8'hFF);
    step(1'b1, 1'b0, 2'd1, 8'hFF);
    step(1'b1, 1'b0, 2'd0, 8'h02);
    step(1'b0, 1'b1, 2'd1, 8'h00);
    chk("attr_rdata", {8'd0, cpu_rdata}, {8'd0, 8'hFF & MASK});
    se_chk("attr_se02", 8'h02, 8'hFF & MASK);
    se_chk("attr_se03", 8'h03, 8'hFF);

    // Even-start DMA from page 02, then odd start rotated by OAMADDR=04 with CPU noise.
    step(1'b1, 1'b0, 2'd0, 8'h00);
    run_dma(8'h02, 8'h5A, 0, 1'b0);
    step(1'b1, 1'b0, 2'd0, 8'h04);
    run_dma(8'h02, 8'h5A, 1, 1'b1);
    step(1'b0, 1'b1, 2'd1, 8'h00);
    chk("oamaddr_restored", {8'd0, cpu_rdata}, {8'd0, 8'h5A});

    // Reset partway through: the first 100 bytes land, the rest stay.
    step(1'b1, 1'b0, 2'd0, 8'h00);
    m_xor = 8'hA5;
    step(1'b1, 1'b0, 2'd2, 8'h03);
    for (int i = 0; i < 400 && m_written < 100; i++) nop();
    reset = 1'b1; #1;
    chk("midrst_halt", {15'd0, cpu_halt}, 16'd0);
    chk("midrst_busy", {15'd0, dma_busy}, 16'd0);
    chk("midrst_dma_rd", {15'd0, dma_rd}, 16'd0);
    m_dma = 1'b0; m_addr = 0; m_rdata = 0;
    se_chk("midrst_oam99", 8'd99, 8'd99 ^ 8'hA5);
    se_chk("midrst_oam100", 8'd100, 8'd96 ^ 8'h5A);
    se_chk("midrst_oam255", 8'd255, 8'd251 ^ 8'h5A);
    @(negedge clock); reset = 1'b0;
    run_dma(8'h03, 8'hA5, 0, 1'b0);

    // Random register traffic, occasionally kicking off a DMA.
    for (int i = 0; i < 500; i++) begin
      logic [1:0] rg;
      rg = 2'($urandom);
      if (rg == 2'd2 && $urandom_range(0, 15) != 0) rg = 2'd1;
      step(1'($urandom), 1'($urandom), rg, 8'($urandom));
    end
    for (int i = 0; i < 700 && m_dma; i++) nop();
    nop();
    chk("final_halt", {15'd0, cpu_halt}, 16'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
